// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus between the PC unit and the rest of the single-cycle core.
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic [31:0] instruction;
  logic        restart;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        misalign_trap;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_target,
           instruction, restart,
    input  pc, pc_plus4, fetch_valid, halted, misalign_trap
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_target,
           instruction, restart,
    output pc, pc_plus4, fetch_valid, halted, misalign_trap
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage with halt detection and restart.
// Optional misaligned-JR trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'h0000_000C,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        trap_q;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    if (bus.jump_reg) begin
      next_pc = bus.jr_target & 32'hFFFF_FFFC;
    end else if (bus.jump) begin
      next_pc = {pc_plus4[31:28], bus.jump_index, 2'b00};
    end else if (bus.branch_taken) begin
      next_pc = pc_plus4 + (bus.branch_offset << 2);
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= StBoot;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          if (!bus.stall) begin
            if (bus.instruction == HALT_WORD) begin
              state_q <= StHalt;
            end
`ifdef PC_MISALIGN_TRAP_EN
            else if (bus.jump_reg && (bus.jr_target[1:0] != 2'b00)) begin
              pc_q   <= EXC_VECTOR;
              trap_q <= 1'b1;
            end
`endif
            else begin
              pc_q <= next_pc;
            end
          end
        end
        StHalt: begin
          if (bus.restart) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
          end
        end
        // Encoding 2'd3 is unreachable; recover through BOOT.
        default: state_q <= StBoot;
      endcase
    end
  end

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_exc_vector;
  assign unused_exc_vector = ^{EXC_VECTOR, trap_q};
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = (state_q == StRun);
  assign bus.halted      = (state_q == StHalt);
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_trap = trap_q;
`else
  assign bus.misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed test-plan steps followed by random cycles.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HALTW  = 32'h0000_000C;
  localparam logic [31:0] EXCV   = 32'h0000_0080;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC  (RST_PC),
    .HALT_WORD (HALTW),
    .EXC_VECTOR(EXCV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_trap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_offset  = 32'h0;
    bus.jump           = 1'b0;
    bus.jump_index     = 26'h0;
    bus.jump_reg       = 1'b0;
    bus.jr_target      = 32'h0;
    bus.instruction    = 32'h0;
    bus.restart        = 1'b0;
  endtask

  // Advance the model by one clock using the spec rules directly.
  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (reset) begin
      m_pc = RST_PC; m_mode = 0; m_trap = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (bus.restart) begin m_pc = RST_PC; m_mode = 1; end
    end else if (!bus.stall) begin
      if (bus.instruction == HALTW) m_mode = 2;
      else if (TRAP_EN && bus.jump_reg && (bus.jr_target % 4 != 0)) begin
        m_pc = EXCV; m_trap = 1;
      end
      else if (bus.jump_reg) m_pc = bus.jr_target - (bus.jr_target % 4);
      else if (bus.jump) m_pc = (seq & 32'hF000_0000) + 32'(bus.jump_index) * 4;
      else if (bus.branch_taken) m_pc = seq + bus.branch_offset * 4;
      else m_pc = seq;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".pc4"}, bus.pc_plus4, m_pc + 32'd4);
    chk({tag, ".fv"}, {31'b0, bus.fetch_valid}, {31'b0, m_mode == 1});
    chk({tag, ".halt"}, {31'b0, bus.halted}, {31'b0, m_mode == 2});
    chk({tag, ".trap"}, {31'b0, bus.misalign_trap}, {31'b0, m_trap});
  endtask

  task automatic goto_pc(input logic [31:0] target);
    idle();
    bus.jump_reg  = 1'b1;
    bus.jr_target = target;
    cycle("goto");
    idle();
  endtask

  initial begin
    m_mode = 0; m_pc = RST_PC; m_trap = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    cycle("rst0");
    cycle("rst1");
    idle();
    #1;
    chk("boot.pc", bus.pc, 32'h0);
    chk("boot.fv", {31'b0, bus.fetch_valid}, 32'h0);
    cycle("run0");
    cycle("run4");
    cycle("run8");
    chk("seq.pc8", bus.pc, 32'h8);

    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFE;
    cycle("br_back");
    chk("br.pc4", bus.pc, 32'h4);

    goto_pc(32'h1000_0010);
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000_0040;
    cycle("jump");
    chk("jump.pc", bus.pc, 32'h1000_0100);

    bus.jump_reg  = 1'b1;
    bus.jr_target = 32'h0000_0200;
    cycle("jr_over_j");
    chk("jr.pc", bus.pc, 32'h200);

    goto_pc(32'hC);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'h4;
    for (int i = 0; i < 3; i++) cycle("stall");
    chk("stall.pc", bus.pc, 32'hC);
    bus.stall = 1'b0;
    cycle("stall_rel");
    chk("stall_rel.pc", bus.pc, 32'h20);

    goto_pc(32'h14);
    bus.instruction = HALTW;
    cycle("halt");
    for (int i = 0; i < 5; i++) begin
      bus.stall        = 1'($urandom);
      bus.jump         = 1'b1;
      bus.branch_taken = 1'b1;
      cycle("halt_hold");
    end
    chk("halt.pc", bus.pc, 32'h14);
    idle();
    bus.restart = 1'b1;
    cycle("restart");
    chk("restart.fv", {31'b0, bus.fetch_valid}, 32'h1);
    bus.restart     = 1'b0;
    bus.instruction = HALTW;
    cycle("halt2");
    reset       = 1'b1;
    bus.restart = 1'b1;
    cycle("rst_restart");
    idle();
    cycle("boot2");

    goto_pc(32'hFFFF_FFFC);
    cycle("wrap");
    chk("wrap.pc", bus.pc, 32'h0);
    bus.stall       = 1'b1;
    bus.instruction = HALTW;
    cycle("stalled_halt");
    idle();

    bus.jump_reg  = 1'b1;
    bus.jr_target = 32'h0000_0203;
    cycle("misalign");
    chk("misalign.pc", bus.pc, TRAP_EN ? 32'h80 : 32'h200);
    idle();
    bus.instruction = HALTW;
    cycle("mis_halt");
    idle();
    bus.restart = 1'b1;
    cycle("mis_restart");
    chk("mis_sticky", {31'b0, bus.misalign_trap}, {31'b0, TRAP_EN});
    idle();

    for (int i = 0; i < 400; i++) begin
      reset              = ($urandom_range(0, 49) == 0);
      bus.stall          = ($urandom_range(0, 4) == 0);
      bus.branch_taken   = 1'($urandom);
      bus.branch_offset  = $urandom;
      bus.jump           = ($urandom_range(0, 3) == 0);
      bus.jump_index     = 26'($urandom);
      bus.jump_reg       = ($urandom_range(0, 5) == 0);
      bus.jr_target      = $urandom;
      bus.instruction    = ($urandom_range(0, 7) == 0) ? HALTW : $urandom;
      bus.restart        = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and next-PC stage feeding the instruction memory address input. Closes the fetch loop of the single-cycle MIPS core.
- Each cycle it holds the current PC and drives it to instruction memory. It watches the returned 32-bit instruction word and registers the next PC on the rising clock edge.
- Next PC is one of: sequential (+4), branch, jump, or jump-register.
- Also provides halt detection and a restart handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on restart.
- HALT_WORD, 32'h0000_000C, instruction encoding (syscall) that halts fetch.
- EXC_VECTOR, 32'h0000_0080, trap target; used only with PC_MISALIGN_TRAP_EN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC this cycle
- branch_taken  input  1  take branch this cycle
- branch_offset  input  32  sign-extended imm16, word offset
- jump  input  1  J/JAL this cycle
- jump_index  input  26  instr[25:0]
- jump_reg  input  1  JR this cycle
- jr_target  input  32  rs register value
- instruction  input  32  word returned by instruction memory for pc
- pc  output  32  current PC, drives instruction memory address
- pc_plus4  output  32  pc + 4 (combinational, for link/branch base)
- fetch_valid  output  1  instruction at pc is to be executed
- halted  output  1  unit is in HALT
- restart  input  1  leave HALT
- misalign_trap  output  1  sticky trap flag (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset. All state is updated on the rising edge of clk.
- Reset values: pc=RESET_PC, state=BOOT, fetch_valid=0, halted=0, misalign_trap=0. Reset overrides every other input, including restart.
- State encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2. Value 2'd3 is illegal and goes to BOOT on the next edge.
- BOOT: lasts one cycle after reset deasserts. pc holds, fetch_valid=0, halted=0. Always goes to RUN.
- RUN:
  - fetch_valid=1, halted=0.
  - If stall=1: pc holds and all other inputs are ignored.
  - If stall=0 and instruction==HALT_WORD: go to HALT and pc holds at the halt address. Next-PC inputs are ignored.
  - Otherwise pc <= next_pc.
- HALT:
  - fetch_valid=0, halted=1, pc holds.
  - restart=1 loads pc<=RESET_PC and enters RUN directly (no BOOT cycle).
  - stall is ignored in HALT.
- next_pc priority: jump_reg > jump > branch_taken > sequential.
  - jump_reg: {jr_target[31:2],2'b00}. Low bits are forced to zero when the feature is off.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: pc_plus4 + {branch_offset[29:0],2'b00}, 32-bit modular.
  - sequential: pc_plus4.
- Arithmetic: all adds are 32-bit and discard the carry. pc=32'hFFFF_FFFC sequential gives 32'h0000_0000.
- Latency: next_pc is combinational from the inputs. pc updates at the edge; pc_plus4 follows pc with zero latency.
- fetch_valid and halted are decoded from the state register; they are not combinational from the inputs.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: in RUN with stall=0 and jump_reg=1 and jr_target[1:0]!=0:
  - pc<=EXC_VECTOR and misalign_trap<=1, taking priority over all other next-PC sources.
  - misalign_trap is sticky until reset; restart does not clear it.
  - An aligned jr_target behaves normally.
- Not defined: misalign_trap is tied 0 and jr_target low bits are silently cleared.

Test Plan:
- Reset then run: reset=1 for 2 cycles, then release with all controls 0 and instruction=0. Cycle 1 after release: pc=0, fetch_valid=0 (BOOT). Then pc steps 0, 4, 8, with fetch_valid=1.
- Branch and jump:
  - At pc=8, branch_taken=1 with branch_offset=32'hFFFF_FFFE gives pc=4.
  - At pc=32'h1000_0010, jump=1 with jump_index=26'h000_0040 gives pc=32'h1000_0100.
  - jump_reg=1 and jump=1 together with jr_target=32'h0000_0200 gives pc=32'h200.
- Stall: stall=1 for 3 cycles at pc=12 with branch_taken=1. pc stays 12. After release, the branch is taken.
- Halt and restart:
  - instruction=32'h0000_000C at pc=20 gives halted=1, fetch_valid=0, and pc stuck at 20 over 5 cycles.
  - restart=1 gives pc=0 and RUN.
  - reset=1 and restart=1 together give BOOT.
- Wrap and stalled halt: pc=32'hFFFF_FFFC sequential gives pc=0. HALT_WORD presented with stall=1 does not halt.
- Misaligned JR: jr_target=32'h0000_0203.
  - With PC_MISALIGN_TRAP_EN: pc=32'h80 and misalign_trap=1, and the flag stays 1 after restart.
  - Without it: pc=32'h200 and misalign_trap=0.
